// File: rtl/int_to_fp_seq_if.sv
// Handshake bundle for int_to_fp_seq: input operand channel plus result channel.
// Ports: in_valid/in_ready/in_int (operand), out_valid/out_ready/fp (result {sign, exp, man}).
// master = producer/consumer side (bench), slave = converter side.
interface int_to_fp_seq_if #(
  parameter int INT_W = 8,
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INT_W-1:0]       in_int;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   fp;

  modport master (
    output in_valid, in_int, out_ready,
    input  in_ready, out_valid, fp
  );

  modport slave (
    input  in_valid, in_int, out_ready,
    output in_ready, out_valid, fp
  );
endinterface

// File: rtl/int_to_fp_seq.sv
// Sequential signed-integer to normalized float converter, one left shift per cycle.
// Latency: k+1 cycles from accept to out_valid (k = leading zeros of |in_int|), 1 cycle for zero.
// Backpressure: result held in DONE until out_ready; no accept outside IDLE.
// Ports: clk, reset_n (async active-low), bus (slave side of int_to_fp_seq_if).
module int_to_fp_seq #(
  parameter int INT_W = 8,
  parameter int EXP_W = 4,
  parameter int MAN_W = 8,
  parameter int RND   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  int_to_fp_seq_if.slave     bus
);
  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam logic [INT_W-1:0] ONE = INT_W'(1);

  if (INT_W < 2) begin : g_bad_int_w
    $error("INT_W must be at least 2");
  end
  if (MAN_W < 2) begin : g_bad_man_w
    $error("MAN_W must be at least 2");
  end
  if ((1 << EXP_W) <= INT_W + 1) begin : g_bad_exp_w
    $error("EXP_W too small: need 2^EXP_W > INT_W+1");
  end

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              sign;
  logic [INT_W-1:0]  mag;
  logic [EXP_W-1:0]  exponent;
  logic [FP_W-1:0]   fp_q;
  logic [INT_W-1:0]  mag_in;
  logic [MAN_W-1:0]  man_c;
  logic              exp_inc;

  // Two's-complement negate; the most negative value maps to 2^(INT_W-1),
  // which is still representable as an INT_W-bit unsigned magnitude.
  assign mag_in = bus.in_int[INT_W-1] ? (~bus.in_int + ONE) : bus.in_int;

  // Mantissa formation from the normalized magnitude.
  if (INT_W <= MAN_W) begin : g_widen
    always_comb begin
      man_c = '0;
      man_c[MAN_W-1 -: INT_W] = mag;
    end
    assign exp_inc = 1'b0;
  end else begin : g_narrow
    logic             rnd_bit;
    logic [MAN_W:0]   sum;
    assign rnd_bit = (RND != 0) & mag[INT_W-MAN_W-1];
    assign sum     = {1'b0, mag[INT_W-1 -: MAN_W]} + {{MAN_W{1'b0}}, rnd_bit};
    // Carry out means the mantissa rolled over to 1.000..0 * 2: renormalize.
    assign exp_inc = sum[MAN_W];
    assign man_c   = sum[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : sum[MAN_W-1:0];
    if (INT_W - MAN_W >= 2) begin : g_sticky
      // Bits below the round bit never influence round-half-up.
      logic unused_low;
      assign unused_low = ^mag[INT_W-MAN_W-2:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = NORM;
      NORM:    if (mag == '0 || mag[INT_W-1]) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from the state flops
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign     <= 1'b0;
      mag      <= '0;
      exponent <= '0;
      fp_q     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign     <= bus.in_int[INT_W-1];
          mag      <= mag_in;
          exponent <= EXP_W'(INT_W);
        end
        NORM: begin
          if (mag == '0) begin
            sign <= 1'b0;
            fp_q <= '0;
          end else if (!mag[INT_W-1]) begin
            mag      <= mag << 1;
            exponent <= exponent - EXP_W'(1);
          end else begin
            fp_q <= {sign, exponent + EXP_W'(exp_inc), man_c};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fp = fp_q;

endmodule

// File: doc/int_to_fp_seq.md
INT_TO_FP_SEQ -- requirements
Module: int_to_fp_seq

Interface
REQ-001 Parameter INT_W, default 8: signed two's-complement input width, minimum 2.
REQ-002 Parameter EXP_W, default 4: unsigned exponent width; elaboration SHALL fail unless 2^EXP_W > INT_W+1.
REQ-003 Parameter MAN_W, default 8: normalized mantissa width, minimum 2.
REQ-004 Parameter RND, default 0: 0 = truncate, 1 = round-half-up on the first discarded bit.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-007 in_valid  input  1  in_int is valid.
REQ-008 in_ready  output  1  block can accept in_int.
REQ-009 in_int  input  INT_W  signed integer operand.
REQ-010 out_valid  output  1  fp holds a completed result.
REQ-011 out_ready  input  1  consumer accepts fp.
REQ-012 fp  output  1+EXP_W+MAN_W  {sign, exp, man}; value = (-1)^sign * 0.man * 2^exp.

Function
REQ-013 Format: a nonzero result SHALL have man[MAN_W-1]=1; zero input SHALL give fp all zeros.
REQ-014 States IDLE, NORM, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: when in_valid=1, the block SHALL register sign=in_int[INT_W-1], mag=|in_int| as INT_W-bit unsigned, and exp=INT_W, then go to NORM.
REQ-016 Most negative input (-2^(INT_W-1)) SHALL give magnitude 2^(INT_W-1), with no overflow.
REQ-017 NORM, mag=0: the block SHALL go to DONE with fp=0, sign cleared.
REQ-018 NORM, mag MSB=0: the block SHALL shift mag left 1 bit, decrement exp, and stay in NORM; exactly one shift per cycle.
REQ-019 NORM, mag MSB=1: the block SHALL form man, load fp, and go to DONE.
REQ-020 Forming man when INT_W<=MAN_W: man = mag with (MAN_W-INT_W) zeros appended at the LSB end.
REQ-021 Forming man when INT_W>MAN_W: man = top MAN_W bits of mag; if RND=1 and the next bit is 1, man is incremented.
REQ-022 If that increment overflows, the block SHALL set man=100..0 and exp=exp+1.
REQ-023 Latency, accept edge to out_valid=1: k+1 cycles, where k = leading zeros of the INT_W-bit magnitude (0..INT_W-1); zero input: 1 cycle.
REQ-024 DONE: fp and out_valid SHALL be held stable until out_ready=1, then the block returns to IDLE the next cycle.
REQ-025 There SHALL be no accept in DONE; back-to-back throughput is one result per (latency+2) cycles minimum.
REQ-026 in_int SHALL be sampled only at accept; later changes SHALL not affect the in-flight result.
REQ-027 Registered outputs only; no combinational path from in_valid or out_ready to any output.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, and fp, mag, exp, sign = 0, regardless of state.
REQ-029 An operation interrupted by reset SHALL be discarded; the first post-reset accept SHALL behave as from power-up.
REQ-030 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-031 Defaults; in_int = 0, 1, -128, 127 with out_ready=1 -> fp = 0x0000, 0x0180, 0x1880, 0x07FE; latency 1, 8, 1, 2 cycles.
REQ-032 Defaults; sweep all 256 inputs -> each fp matches the reference model, and sign=1 exactly for negative inputs.
REQ-033 INT_W=12, EXP_W=4, MAN_W=8; in_int=2047 -> RND=0: fp = 0x0BFF; RND=1: fp = 0x0C80 (overflow renormalization).
REQ-034 in_int=5 accepted, out_ready held 0 for 10 cycles -> fp = 0x03A0 stays stable, in_ready stays 0, in_valid is ignored; out_ready=1 -> IDLE the next cycle.
REQ-035 in_int=1 accepted, in_int changed on the following cycle -> result is still 0x0180.
REQ-036 reset_n pulsed low during NORM -> out_valid=0 and in_ready=1 immediately; the next conversion of -1 -> fp = 0x1180.
